// File: rtl/micro_hash_verifier_pkg.sv
// Purpose: shared constants and types for the micro-hash generator/verifier pair.
// Contents: init vector H_INIT0..2, round constants K_LO/K_HI and the switch round,
//           byte type, working-register struct, FSM state encoding.
package micro_hash_verifier_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t H_INIT0 = 8'h01;
  localparam byte_t H_INIT1 = 8'h89;
  localparam byte_t H_INIT2 = 8'hFE;

  localparam byte_t K_LO = 8'h99;
  localparam byte_t K_HI = 8'hA1;

  // Rounds 0..K_SWITCH_ROUND (inclusive) use K_LO and a^b; later rounds use K_HI and a^c.
  localparam int K_SWITCH_ROUND = 16;

  typedef struct packed {
    byte_t a;
    byte_t b;
    byte_t c;
  } work_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/micro_hash_verifier_round.sv
// Purpose: one micro-hash compression round, (a,b,c,W[i],i) -> (a',b',c').
// Latency: purely combinational, zero cycles; no flow control.
// Ports: s_i current working regs, w_i schedule byte W[i], round_i index i, s_o next working regs.
module micro_hash_verifier_round
  import micro_hash_verifier_pkg::*;
#(
  parameter int RW = 5
) (
  input  work_t         s_i,
  input  byte_t         w_i,
  input  logic [RW-1:0] round_i,
  output work_t         s_o
);

  byte_t k;
  byte_t x;

  always_comb begin
    if (round_i <= RW'(K_SWITCH_ROUND)) begin
      k = K_LO;
      x = s_i.a ^ s_i.b;
    end else begin
      k = K_HI;
      x = s_i.a ^ s_i.c;
    end
    s_o.a = s_i.b ^ s_i.c;
    s_o.b = {s_i.c[3:0], 4'h0};
    // All byte arithmetic wraps mod 256.
    s_o.c = x + k + w_i;
  end

endmodule

// File: rtl/micro_hash_verifier.sv
// Purpose: recompute the 24-bit micro-hash of a claimed (payload, nonce) and test it against target.
// Latency: capture edge E0, rounds E1..E32, hash/valid/done on E33, idle again at E34 (35-cycle period).
// Backpressure: none; verify is sampled only in IDLE and ignored while busy.
// Ports: clk, reset_L (async active-low); verify/payload/nonce/target in; busy/done/valid/hash out.
module micro_hash_verifier
  import micro_hash_verifier_pkg::*;
#(
  parameter int ROUNDS      = 32,
  parameter int CHECK_BYTES = 2
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        verify,
  input  logic [95:0] payload,
  input  logic [31:0] nonce,
  input  logic [7:0]  target,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [23:0] hash
);

  localparam int CW = $clog2(ROUNDS);

  state_e            state_q, state_d;
  logic [CW-1:0]     rnd_q, rnd_d;
  // Sliding schedule window: w_q[15] is W[i], w_q[15-j] is W[i+j].
  logic [15:0][7:0]  w_q, w_d;
  work_t             s_q, s_d, s_next;
  byte_t             target_q, target_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [23:0]       hash_q, hash_d;
  logic [23:0]       hash_fin;
  logic              meets;
  byte_t             w_new;

  micro_hash_verifier_round #(.RW(CW)) u_round (
    .s_i    (s_q),
    .w_i    (w_q[15]),
    .round_i(rnd_q),
    .s_o    (s_next)
  );

  always_comb begin
    // W[i+16] = W[i+13] | (W[i+7] ^ W[i+2])
    w_new    = w_q[2] | (w_q[8] ^ w_q[13]);
    hash_fin = {byte_t'(H_INIT0 + s_q.a), byte_t'(H_INIT1 + s_q.b), byte_t'(H_INIT2 + s_q.c)};
    // Only the CHECK_BYTES most-significant bytes take part; target 0 can never be met.
    meets = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (j < CHECK_BYTES && hash_fin[23-8*j -: 8] >= target_q) meets = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    w_d      = w_q;
    s_d      = s_q;
    target_d = target_q;
    busy_d   = busy_q;
    done_d   = done_q;
    valid_d  = valid_q;
    hash_d   = hash_q;
    case (state_q)
      ST_IDLE: begin
        if (verify) begin
          w_d      = {payload, nonce};
          target_d = target;
          s_d      = {H_INIT0, H_INIT1, H_INIT2};
          rnd_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_ROUND;
        end
      end
      ST_ROUND: begin
        s_d   = s_next;
        w_d   = {w_q[14:0], w_new};
        rnd_d = rnd_q + 1'b1;
        if (rnd_q == CW'(ROUNDS - 1)) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        hash_d  = hash_fin;
        valid_d = meets;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      rnd_q    <= '0;
      w_q      <= '0;
      s_q      <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      hash_q   <= '0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      w_q      <= w_d;
      s_q      <= s_d;
      target_q <= target_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      hash_q   <= hash_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign hash  = hash_q;

endmodule

// File: tb/tb_micro_hash_verifier.sv
// Bench for micro_hash_verifier: vector table plus reset / busy-request / back-to-back sequences.
module tb_micro_hash_verifier;

  logic        clk;
  logic        reset_L;
  logic        verify;
  logic [95:0] payload;
  logic [31:0] nonce;
  logic [7:0]  target;
  logic        busy;
  logic        done;
  logic        valid;
  logic [23:0] hash;

  micro_hash_verifier dut (
    .clk    (clk),
    .reset_L(reset_L),
    .verify (verify),
    .payload(payload),
    .nonce  (nonce),
    .target (target),
    .busy   (busy),
    .done   (done),
    .valid  (valid),
    .hash   (hash)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [95:0] p;
    logic [31:0] n;
    logic [7:0]  t;
    logic [23:0] h;
    logic        v;
  } vec_t;

  typedef struct {
    logic [23:0] h;
    logic        v;
  } exp_t;

  localparam logic [95:0] P1 = 96'h397d9f2f40ca9e6c6b1f3324;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   done_cnt = 0;
  int   done_cyc_q[$];
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[6];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference model: full 32-entry schedule, then 32 rounds, then finalisation (CHECK_BYTES = 2).
  function automatic logic [24:0] model(input logic [95:0] p, input logic [31:0] n, input logic [7:0] t);
    logic [7:0]   w [32];
    logic [127:0] m;
    logic [7:0]   a, b, c, x, k, na, nb, h0, h1, h2;
    m = {p, n};
    for (int i = 0; i < 16; i++) w[i] = m[127-8*i -: 8];
    for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    a = 8'h01; b = 8'h89; c = 8'hFE;
    for (int i = 0; i < 32; i++) begin
      if (i <= 16) begin k = 8'h99; x = a ^ b; end
      else         begin k = 8'hA1; x = a ^ c; end
      na = b ^ c;
      nb = c << 4;
      c  = x + k + w[i];
      a  = na;
      b  = nb;
    end
    h0 = 8'h01 + a;
    h1 = 8'h89 + b;
    h2 = 8'hFE + c;
    return {(h0 < t) && (h1 < t), h0, h1, h2};
  endfunction

  // Scoreboard: every done pops the oldest expected result.
  always @(negedge clk) begin
    if (reset_L && done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        timeout_fail("unexpected_done");
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_hash", 32'(hash), 32'(mon_e.h));
        check("sb_valid", 32'(valid), 32'(mon_e.v));
      end
    end
  end

  task automatic push_exp(input logic [95:0] p, input logic [31:0] n, input logic [7:0] t);
    logic [24:0] r;
    exp_t e;
    r   = model(p, n, t);
    e.h = r[23:0];
    e.v = r[24];
    sb_q.push_back(e);
  endtask

  task automatic start_run(input logic [95:0] p, input logic [31:0] n, input logic [7:0] t,
                           output int cap);
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy) timeout_fail("idle_wait");
    payload = p;
    nonce   = n;
    target  = t;
    verify  = 1'b1;
    @(posedge clk);
    #1;
    cap    = cyc;
    verify = 1'b0;
    push_exp(p, n, t);
  endtask

  task automatic wait_done(input int base, input string name);
    int g;
    g = 0;
    while (done_cnt <= base && g < 80) begin
      @(negedge clk);
      g++;
    end
    if (done_cnt <= base) timeout_fail(name);
  endtask

  initial begin
    int          cap, base, c0, low, in_win;
    logic [31:0] nsol;
    logic [24:0] r;
    bit          found;

    reset_L = 1'b0;
    verify  = 1'b0;
    payload = '0;
    nonce   = '0;
    target  = '0;

    // Act as the generator: find a nonce for P1 meeting target 0x0a.
    found = 1'b0;
    nsol  = '0;
    for (int n = 0; n < 200000 && !found; n++) begin
      r = model(P1, 32'(n), 8'h0a);
      if (r[24]) begin
        found = 1'b1;
        nsol  = 32'(n);
      end
    end
    if (!found) timeout_fail("nonce_search");

    vecs[0] = '{P1, nsol, 8'h0a, 24'h0, 1'b0};
    vecs[1] = '{P1, nsol + 32'd1, 8'h0a, 24'h0, 1'b0};
    vecs[2] = '{P1, 32'h12345678, 8'h00, 24'h0, 1'b0};
    vecs[3] = '{{$urandom(), $urandom(), $urandom()}, $urandom(), 8'hff, 24'h0, 1'b0};
    vecs[4] = '{{96{1'b1}}, 32'hffffffff, 8'h80, 24'h0, 1'b0};
    vecs[5] = '{96'h0, 32'h0, 8'h40, 24'h0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      r = model(vecs[i].p, vecs[i].n, vecs[i].t);
      vecs[i].h = r[23:0];
      vecs[i].v = r[24];
    end

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_hash", 32'(hash), 0);
    reset_L = 1'b1;

    // Table-driven runs, each with latency check.
    for (int i = 0; i < 6; i++) begin
      base = done_cnt;
      start_run(vecs[i].p, vecs[i].n, vecs[i].t, cap);
      wait_done(base, "vec_done");
      if (done_cyc_q.size() > base) check("vec_latency", 32'(done_cyc_q[base] - cap), 33);
      if (i == 0) check("case1_valid", 32'(valid), 1);
      if (i == 1) check("case2_hash_differs", 32'(hash != vecs[0].h), 1);
      if (i == 2) check("target0_valid", 32'(valid), 0);
    end

    // Request during run, inputs scrambled after capture.
    base = done_cnt;
    start_run(P1, nsol, 8'h0a, cap);
    repeat (10) @(negedge clk);
    verify  = 1'b1;
    payload = '0;
    nonce   = '0;
    target  = 8'hff;
    @(negedge clk);
    verify = 1'b0;
    check("busy_midrun", 32'(busy), 1);
    wait_done(base, "midrun_done");
    check("midrun_hash", 32'(hash), 32'(vecs[0].h));
    repeat (40) @(negedge clk);
    check("midrun_no_extra_done", 32'(done_cnt - base), 1);

    // Reset in the middle of a run.
    base = done_cnt;
    start_run(P1, nsol, 8'h0a, cap);
    repeat (12) @(negedge clk);
    reset_L = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_valid", 32'(valid), 0);
    check("arst_hash", 32'(hash), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_no_done", 32'(done_cnt - base), 0);
    base = done_cnt;
    start_run(P1, nsol, 8'h0a, cap);
    wait_done(base, "post_reset_done");
    check("post_reset_hash", 32'(hash), 32'(vecs[0].h));
    check("post_reset_valid", 32'(valid), 1);

    // verify held high for 80 cycles: captures at E0, E35, E70.
    base = done_cnt;
    @(negedge clk);
    payload = P1;
    nonce   = nsol;
    target  = 8'h0a;
    verify  = 1'b1;
    repeat (3) push_exp(P1, nsol, 8'h0a);
    @(posedge clk);
    #1;
    c0  = cyc;
    low = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!busy) low++;
    end
    verify = 1'b0;
    check("b2b_busy_low_cycles", 32'(low), 2);
    in_win = 0;
    for (int k = base; k < done_cyc_q.size(); k++)
      if (done_cyc_q[k] <= c0 + 79) in_win++;
    check("b2b_dones_in_window", 32'(in_win), 2);
    if (done_cyc_q.size() >= base + 2) begin
      check("b2b_first_latency", 32'(done_cyc_q[base] - c0), 33);
      check("b2b_spacing", 32'(done_cyc_q[base+1] - done_cyc_q[base]), 35);
    end else begin
      timeout_fail("b2b_dones");
    end
    wait_done(base + 2, "b2b_third_done");
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/micro_hash_verifier.md
Name: micro_hash_verifier

Overview:
Verifier at the receiving end of the mining interface. It accepts a claimed solution (96-bit payload, 32-bit nonce) plus an 8-bit target and recomputes the 24-bit micro-hash iteratively, one round per clock. It reports the hash and whether the hash meets the target. It sits downstream of sistema_speed and checks its nonceOut/hashOut before a solution is accepted.

Parameters:
ROUNDS, 32, number of compression rounds; only 32 is supported, and the counter width is derived from it.
CHECK_BYTES, 2, number of most-significant hash bytes that must each be < target; legal values are 1 to 3.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_L  input  1  asynchronous, active-low reset.
verify  input  1  start request; sampled only in IDLE.
payload  input  96  block header bytes; captured on the accepted verify edge.
nonce  input  32  claimed nonce; captured with payload.
target  input  8  difficulty threshold; captured with payload.
busy  output  1  high from the capture edge until done falls.
done  output  1  one-cycle pulse when hash and valid are updated.
valid  output  1  1 = captured nonce meets target; held until the next done.
hash  output  24  recomputed hash {H0,H1,H2}; held until the next done.

Behaviour:
- Reset (reset_L = 0, asynchronous):
  - busy, done, valid and hash are forced to 0.
  - The FSM goes to IDLE and the round counter is cleared.
  - Reset mid-run abandons the run; no done is produced for it.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE: on an edge with verify = 1, capture payload, nonce and target into internal registers; busy goes to 1; go to ROUND with i = 0.
- Message schedule:
  - W[0..11] = payload bytes, MSB first (W[0] = payload[95:88]).
  - W[12..15] = nonce bytes, MSB first.
  - W[i] = W[i-3] | (W[i-9] ^ W[i-14]) for i = 16..31, all 8-bit.
  - W may be precomputed combinationally from the captured registers, or held in a shift register.
- Working registers a, b, c are initialised to 8'h01, 8'h89, 8'hFE at capture.
- ROUND: one round per edge, i = 0..ROUNDS-1:
  - For i <= 16: k = 8'h99, x = a ^ b.
  - Otherwise: k = 8'hA1, x = a ^ c.
  - Update: a <= b ^ c; b <= c << 4 (8-bit, upper bits dropped); c <= x + k + W[i] (mod 256).
  - After i = ROUNDS-1, go to FINAL.
- FINAL:
  - hash <= {8'h01+a, 8'h89+b, 8'hFE+c}, each byte mod 256.
  - valid <= 1 iff each of the CHECK_BYTES most-significant hash bytes is strictly less than the captured target.
  - done <= 1; go to DONE.
- DONE: done <= 0, busy <= 0; go to IDLE.
- Latency:
  - Capture edge = E0; rounds execute on E1..E32.
  - hash, valid and done are updated on E33; done is high for exactly one cycle.
  - The earliest next capture is E35: verify is sampled in IDLE, which is entered at E34.
- verify while busy is ignored; input changes after capture have no effect.
- verify held high continuously gives back-to-back runs, one every 35 cycles.
- target = 0 always gives valid = 0.
- Arithmetic wrap-around is mod 256 per byte and carries never cross bytes.

Decomposition:
- Shared package/include micro_hash_defs: constants H_INIT0/1/2 (01, 89, FE), K_LO = 99, K_HI = A1, K_SWITCH_ROUND = 16, BYTE_W = 8, state encodings.
- One natural sub-module, micro_hash_round: combinational, (a, b, c, W[i], i) -> (a', b', c').
  - Shared with the generator so both ends compute the same function.

Test Plan:
1. Run sistema_speed on payload 96'h397d9f2f40ca9e6c6b1f3324 with target 8'h0a, then feed its nonceOut to the verifier -> done exactly 33 cycles after capture, hash == hashOut, valid = 1.
2. Same payload with nonceOut+1, target 8'h0a -> hash equals the C reference model value and differs from the case-1 hash; valid matches the model.
3. Any payload/nonce with target 8'h00 -> valid = 0, and hash still matches the model.
4. verify pulsed at round 10, and payload changed to all-zero during the run -> the second request is ignored and the result matches the originally captured inputs.
5. reset_L dropped at round 12 -> busy, done, valid and hash are 0 immediately; no done pulse; a fresh verify with case-1 inputs reproduces the case-1 result.
6. verify held high for 80 cycles -> exactly two done pulses 35 cycles apart, and busy is low for one cycle between runs.
